// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory bus among mem_operation requesters
//
// Purpose: grants the single-port memory bus to one requester at a time and
// keeps it locked to that requester for as long as it holds mem_operation
// non-zero, so multi-word sequences (address stepping under a held read)
// complete without re-arbitration. Ownership rotates round-robin.
//
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   req_op_i         per-requester 2-bit op (00 none, 01 read, 11 write, 10 illegal)
//   req_addr_i       per-requester address, AW bits per slice
//   req_wdata_i      per-requester write data, DW bits per slice
//   req_rdata_o      memory read data, broadcast unregistered
//   req_opdone_o     per-requester opdone, routed only to the owner
//   mem_op_o         op to memory (owner's op, 10 squashed to 00)
//   mem_addr_o       address to memory
//   mem_wdata_o      write data to memory
//   mem_rdata_i      read data from memory
//   mem_opdone_i     one-cycle completion pulse from memory
//   grant_o          registered one-hot owner, 0 when idle
//   busy_o           high while the bus is owned
//   err_o            sticky: [0] stray opdone, [1] illegal op, [2] hold watchdog

module mem_port_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_HOLD = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2*NUM_REQ-1:0]  req_op_i,
   input  logic [AW*NUM_REQ-1:0] req_addr_i,
   input  logic [DW*NUM_REQ-1:0] req_wdata_i,
   output logic [DW-1:0]         req_rdata_o,
   output logic [NUM_REQ-1:0]    req_opdone_o,
   output logic [1:0]            mem_op_o,
   output logic [AW-1:0]         mem_addr_o,
   output logic [DW-1:0]         mem_wdata_o,
   input  logic [DW-1:0]         mem_rdata_i,
   input  logic                  mem_opdone_i,
   output logic [NUM_REQ-1:0]    grant_o,
   output logic                  busy_o,
   output logic [2:0]            err_o
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [15:0]          hold_cnt_q, hold_cnt_d;
   logic [2:0]           err_q, err_d;

   logic [NUM_REQ-1:0]   req_vec;
   logic                 pick_found;
   logic [IW-1:0]        pick_idx;
   logic [IW-1:0]        g_idx;
   logic [1:0]           g_op;
   logic [AW-1:0]        g_addr;
   logic [DW-1:0]        g_wdata;
   logic                 g_release;
   logic [IW-1:0]        ptr_after;
   logic [15:0]          hold_inc;

   // Any non-zero op (including the illegal 10) counts as a request.
   always_comb begin
      req_vec = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         req_vec[r] = |req_op_i[2*r +: 2];
      end
   end

   // Round-robin search starting at rr_ptr and wrapping; the first hit wins.
   always_comb begin : rr_pick
      int            cand;
      logic [IW-1:0] cand_idx;
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(rr_ptr_q) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IW'(cand);
         if (!pick_found && req_vec[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   // Mux the owner's port; grant_q is one-hot or zero so at most one slice hits.
   always_comb begin
      g_idx   = '0;
      g_op    = 2'b00;
      g_addr  = '0;
      g_wdata = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (grant_q[r]) begin
            g_idx   = IW'(r);
            g_op    = req_op_i[2*r +: 2];
            g_addr  = req_addr_i[AW*r +: AW];
            g_wdata = req_wdata_i[DW*r +: DW];
         end
      end
   end

   assign g_release = (state_q == ST_BUSY) && (g_op == 2'b00);
   assign ptr_after = (g_idx == IW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
   assign hold_inc  = (hold_cnt_q == 16'hFFFF) ? hold_cnt_q : hold_cnt_q + 16'd1;

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (pick_found) state_d = ST_BUSY;
         ST_BUSY: if (g_release)  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: bus pass-through only while owned
   always_comb begin
      mem_op_o     = 2'b00;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      req_opdone_o = '0;
      if (state_q == ST_BUSY) begin
         mem_op_o     = (g_op == 2'b10) ? 2'b00 : g_op;
         mem_addr_o   = g_addr;
         mem_wdata_o  = g_wdata;
         req_opdone_o = grant_q & {NUM_REQ{mem_opdone_i}};
      end
   end

   // Grant, pointer, hold counter and error flags
   always_comb begin
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      hold_cnt_d = hold_cnt_q;
      err_d      = err_q;
      if (state_q == ST_IDLE) begin
         if (mem_opdone_i) begin
            err_d[0] = 1'b1;
         end
         if (pick_found) begin
            grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            hold_cnt_d = 16'd0;
         end
      end else begin
         hold_cnt_d = hold_inc;
         if ({16'd0, hold_inc} >= 32'(MAX_HOLD)) begin
            err_d[2] = 1'b1;
         end
         if (g_op == 2'b10) begin
            err_d[1] = 1'b1;
         end
         if (g_release) begin
            grant_d  = '0;
            rr_ptr_d = ptr_after;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         hold_cnt_q <= 16'd0;
         err_q      <= 3'b000;
      end else begin
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         hold_cnt_q <= hold_cnt_d;
         err_q      <= err_d;
      end
   end

   assign req_rdata_o = mem_rdata_i;
   assign grant_o     = grant_q;
   assign busy_o      = (state_q == ST_BUSY);
   assign err_o       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MH = 8;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [1:0]      op_a    [N];
   logic [AW-1:0]   addr_a  [N];
   logic [DW-1:0]   wdata_a [N];
   logic [2*N-1:0]  req_op;
   logic [AW*N-1:0] req_addr;
   logic [DW*N-1:0] req_wdata;
   logic [DW-1:0]   mem_rdata = '0;
   logic            mem_opdone = 1'b0;

   logic [DW-1:0]   req_rdata_o;
   logic [N-1:0]    req_opdone_o;
   logic [1:0]      mem_op_o;
   logic [AW-1:0]   mem_addr_o;
   logic [DW-1:0]   mem_wdata_o;
   logic [N-1:0]    grant_o;
   logic            busy_o;
   logic [2:0]      err_o;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int r = 0; r < N; r++) begin
         req_op[2*r +: 2]     = op_a[r];
         req_addr[AW*r +: AW] = addr_a[r];
         req_wdata[DW*r +: DW] = wdata_a[r];
      end
   end

   mem_port_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .MAX_HOLD(MH)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_op_i     (req_op),
      .req_addr_i   (req_addr),
      .req_wdata_i  (req_wdata),
      .req_rdata_o  (req_rdata_o),
      .req_opdone_o (req_opdone_o),
      .mem_op_o     (mem_op_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rdata_i  (mem_rdata),
      .mem_opdone_i (mem_opdone),
      .grant_o      (grant_o),
      .busy_o       (busy_o),
      .err_o        (err_o)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   // Behavioural model: owner index (-1 = bus free), rotation pointer,
   // cycles held, sticky error bits.
   int         m_owner = -1;
   int         m_ptr   = 0;
   int         m_hold  = 0;
   logic [2:0] m_err   = 3'b000;
   int         m_cand;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_owner = -1;
         m_ptr   = 0;
         m_hold  = 0;
         m_err   = 3'b000;
      end else if (m_owner < 0) begin
         if (mem_opdone) m_err[0] = 1'b1;
         for (int k = 0; k < N; k++) begin
            m_cand = (m_ptr + k) % N;
            if (m_owner < 0 && op_a[m_cand] != 2'b00) begin
               m_owner = m_cand;
               m_hold  = 0;
            end
         end
      end else begin
         if (op_a[m_owner] == 2'b10) m_err[1] = 1'b1;
         if (m_hold < 65535) m_hold = m_hold + 1;
         if (m_hold >= MH) m_err[2] = 1'b1;
         if (op_a[m_owner] == 2'b00) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
         end
      end
   end

   logic [N-1:0]  e_grant, e_done;
   logic [1:0]    e_op;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata;

   always @(negedge clk) begin
      e_grant = '0;
      e_done  = '0;
      e_op    = 2'b00;
      e_addr  = '0;
      e_wdata = '0;
      if (m_owner >= 0) begin
         e_grant = N'(1) << m_owner;
         e_op    = (op_a[m_owner] == 2'b10) ? 2'b00 : op_a[m_owner];
         e_addr  = addr_a[m_owner];
         e_wdata = wdata_a[m_owner];
         e_done  = mem_opdone ? e_grant : '0;
      end
      check("cyc_grant",  grant_o,      e_grant);
      check("cyc_busy",   busy_o,       m_owner >= 0);
      check("cyc_mem_op", mem_op_o,     e_op);
      check("cyc_addr",   mem_addr_o,   e_addr);
      check("cyc_wdata",  mem_wdata_o,  e_wdata);
      check("cyc_opdone", req_opdone_o, e_done);
      check("cyc_rdata",  req_rdata_o,  mem_rdata);
      check("cyc_err",    err_o,        m_err);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   // Waits for a grant, completes one access, releases; returns owner index.
   task automatic serve(output int g);
      int n;
      g = -1;
      n = 0;
      while (grant_o == '0 && n < 20) begin
         tick();
         n++;
      end
      if (grant_o == '0) begin
         total_cnt++;
         $display("FAIL serve_wait: grant_o=0 after 20 cycles, required nonzero");
         return;
      end
      for (int r = 0; r < N; r++) if (grant_o[r]) g = r;
      mem_opdone = 1'b1;
      tick();
      mem_opdone = 1'b0;
      op_a[g] = 2'b00;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

   int order [5];

   initial begin
      for (int r = 0; r < N; r++) begin
         op_a[r]    = 2'b00;
         addr_a[r]  = 32'h100 * (r + 1);
         wdata_a[r] = 32'hA000_0000 + r;
      end
      #1 reset = 1'b1;
      #2;
      check("rst_grant",  grant_o,  4'b0000);
      check("rst_busy",   busy_o,   1'b0);
      check("rst_err",    err_o,    3'b000);
      check("rst_mem_op", mem_op_o, 2'b00);
      mem_rdata = 32'h1234_5678;
      #1;
      check("rst_rdata", req_rdata_o, 32'h1234_5678);
      @(posedge clk);
      #1 reset = 1'b0;

      // Single requester r2 read
      op_a[2] = 2'b01;
      addr_a[2] = 32'h10;
      tick();
      check("t1_grant", grant_o, 4'b0100);
      check("t1_op",    mem_op_o, 2'b01);
      check("t1_addr",  mem_addr_o, 32'h10);
      tick();
      tick();
      mem_rdata  = 32'hDEAD_BEEF;
      mem_opdone = 1'b1;
      #1;
      check("t1_done",  req_opdone_o, 4'b0100);
      check("t1_rdata", req_rdata_o, 32'hDEAD_BEEF);
      tick();
      mem_opdone = 1'b0;
      op_a[2] = 2'b00;
      #1;
      check("t1_done_once", req_opdone_o, 4'b0000);
      check("t1_hold_grant", grant_o, 4'b0100);
      tick();
      check("t1_release", grant_o, 4'b0000);
      tick();
      check("t1_idle", grant_o, 4'b0000);

      // Round robin r0, r1, r3 together, then r0, r1
      pulse_reset();
      op_a[0] = 2'b01;
      op_a[1] = 2'b01;
      op_a[3] = 2'b01;
      for (int i = 0; i < 3; i++) serve(order[i]);
      op_a[0] = 2'b01;
      op_a[1] = 2'b01;
      for (int i = 3; i < 5; i++) serve(order[i]);
      check("rr_0", order[0], 0);
      check("rr_1", order[1], 1);
      check("rr_2", order[2], 3);
      check("rr_3", order[3], 0);
      check("rr_4", order[4], 1);

      // Burst hold: r1 reads 1..4, r0 waits
      pulse_reset();
      op_a[1] = 2'b01;
      addr_a[1] = 32'd1;
      tick();
      check("b_grant_r1", grant_o, 4'b0010);
      op_a[0] = 2'b01;
      for (int a = 1; a <= 4; a++) begin
         addr_a[1] = a;
         tick();
         mem_opdone = 1'b1;
         #1;
         check("b_done_r1", req_opdone_o, 4'b0010);
         check("b_addr", mem_addr_o, a);
         tick();
         mem_opdone = 1'b0;
         check("b_r0_waits", grant_o, 4'b0010);
      end
      op_a[1] = 2'b00;
      tick();
      check("b_dead", grant_o, 4'b0000);
      tick();
      check("b_grant_r0", grant_o, 4'b0001);
      op_a[0] = 2'b00;
      tick();
      tick();

      // Stray opdone and illegal op
      pulse_reset();
      mem_opdone = 1'b1;
      #1;
      check("s_no_done", req_opdone_o, 4'b0000);
      tick();
      mem_opdone = 1'b0;
      check("s_err", err_o, 3'b001);
      op_a[3] = 2'b01;
      tick();
      check("i_grant", grant_o, 4'b1000);
      op_a[3] = 2'b10;
      #1;
      check("i_op", mem_op_o, 2'b00);
      tick();
      check("i_err", err_o, 3'b011);
      check("i_keep", grant_o, 4'b1000);
      op_a[3] = 2'b00;
      tick();
      tick();

      // Watchdog
      pulse_reset();
      op_a[0] = 2'b01;
      tick();
      repeat (7) tick();
      check("w_before", err_o[2], 1'b0);
      tick();
      check("w_at8", err_o[2], 1'b1);
      tick();
      tick();
      check("w_keep", grant_o, 4'b0001);

      // Reset mid-access
      op_a[0] = 2'b00;
      tick();
      op_a[2]    = 2'b11;
      addr_a[2]  = 32'h40;
      wdata_a[2] = 32'hCAFE_F00D;
      tick();
      check("r_op",    mem_op_o, 2'b11);
      check("r_wdata", mem_wdata_o, 32'hCAFE_F00D);
      op_a[1] = 2'b01;
      tick();
      check("r_wait", grant_o, 4'b0100);
      reset = 1'b1;
      #1;
      check("r_op0",   mem_op_o, 2'b00);
      check("r_grant0", grant_o, 4'b0000);
      check("r_err0",  err_o, 3'b000);
      tick();
      reset = 1'b0;
      tick();
      check("r_first", grant_o, 4'b0010);
      op_a[1] = 2'b00;
      op_a[2] = 2'b00;
      tick();
      tick();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter sharing one single-port memory bus among up to NUM_REQ accelerator engines (matrix convolution and related engines) that use the 2-bit mem_operation / mem_opdone handshake. Each requester keeps its native port protocol: it drives mem_operation, address and write data, and waits for mem_opdone. The arbiter locks the memory to one requester for as long as that requester holds mem_operation non-zero. This covers multi-word sequences such as parameter fetch, where the requester increments the address under a continuous read.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- AW, 32: address width
- DW, 32: data width
- MAX_HOLD, 1024: hold-cycle threshold for the watchdog flag
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_op_i  in  2*NUM_REQ  per-requester mem_operation (slice r = bits [2r+1:2r]): 00 none, 01 read, 11 write, 10 illegal
- req_addr_i  in  AW*NUM_REQ  per-requester address, slice r
- req_wdata_i  in  DW*NUM_REQ  per-requester write data, slice r
- req_rdata_o  out  DW  memory read data, broadcast to all requesters
- req_opdone_o  out  NUM_REQ  per-requester mem_opdone, one-hot or zero
- mem_op_o  out  2  to memory
- mem_addr_o  out  AW  to memory
- mem_wdata_o  out  DW  to memory
- mem_rdata_i  in  DW  from memory
- mem_opdone_i  in  1  from memory; one-cycle pulse per completed access
- grant_o  out  NUM_REQ  registered one-hot grant, 0 when idle
- busy_o  out  1  state == BUSY
- err_o  out  3  sticky flags: [0] stray opdone, [1] illegal op 10, [2] hold exceeded MAX_HOLD

## Operation
- States: IDLE, BUSY. Registers: state, grant (one-hot), rr_ptr (index), hold_cnt (16 bit, saturating), err.
- IDLE: request vector q[r] = (req_op_i slice r != 00). If q is non-zero:
  - Select the first r with q[r] set, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - Register grant = onehot(r), hold_cnt = 0, state -> BUSY.
- BUSY, granted requester g:
  - Combinational pass-through: mem_op_o = req_op_i[g], mem_addr_o = req_addr_i[g], mem_wdata_o = req_wdata_i[g].
  - req_opdone_o = grant & {NUM_REQ{mem_opdone_i}}.
  - hold_cnt increments each cycle, saturating.
  - When req_op_i[g] == 00 (sampled at the edge): state -> IDLE, grant -> 0, rr_ptr -> (g+1) mod NUM_REQ.
- In IDLE, mem_op_o, mem_addr_o and mem_wdata_o are 0, and req_opdone_o is 0.
- req_rdata_o = mem_rdata_i at all times (unregistered).
- Operation changes while granted (read -> write, address increments) pass through without re-arbitration.
- Illegal op 10 on the granted requester:
  - Forwarded to mem_op_o as 00.
  - err_o[1] set.
  - Does not release the grant.
- mem_opdone_i high while IDLE sets err_o[0]; the pulse is dropped.
- hold_cnt reaching MAX_HOLD sets err_o[2]. The grant is not revoked.
- Errors are cleared only by reset.

## Timing
- Reset (asynchronous): state IDLE, grant 0, rr_ptr 0, hold_cnt 0, err 0. All outputs 0, except req_rdata_o, which follows mem_rdata_i.
- Grant latency: a request first seen at edge N yields grant_o and a driven mem_op_o in cycle N+1.
- Release: requester drops its op in cycle M; at edge M+1 the arbiter returns to IDLE. The earliest next grant is at edge M+2, so there is one dead cycle between owners.
- mem_opdone_i is routed to req_opdone_o in the same cycle (zero latency). The requester must drop or advance its op at the following edge.
- Simultaneous opdone and release in the same cycle: the opdone is still delivered to g.
- A requester that asserts while another holds the grant waits; its op is not forwarded.
- Reset asserted mid-access aborts it immediately. Memory-side cleanup is the memory's responsibility.

## Test plan
- Single requester: r2 issues a read at addr 0x10; memory returns 0xDEADBEEF with opdone 3 cycles later.
  - Required: grant_o = 0100 one cycle after the request.
  - Required: req_opdone_o = 0100 for exactly one cycle, req_rdata_o = 0xDEADBEEF.
  - Required: grant_o = 0 two cycles after r2 drops its op.
- Round robin: r0, r1 and r3 request together from reset.
  - Required: grant order r0, r1, r3.
  - Then r0 and r1 request again: required order r0, r1 (pointer is 0 after r3).
- Burst hold: r1 reads addresses 1..4 under a continuous read with 4 opdones while r0 requests throughout.
  - Required: r0 is not granted until r1 issues 00.
  - Required: r0 is granted exactly 2 cycles after that.
- Stray and illegal ops:
  - opdone while idle -> err_o = 001, no req_opdone_o.
  - Granted r3 drives 10 -> mem_op_o = 00, err_o = 011.
- Watchdog: with MAX_HOLD = 8, r0 holds a read for 10 cycles with no opdone.
  - Required: err_o[2] rises at hold_cnt = 8.
  - Required: grant is retained.
- Reset mid-access: assert reset during a BUSY write.
  - Required: mem_op_o = 00 and grant_o = 0 in the same cycle, err_o = 0.
  - Required: the first post-reset grant goes to the lowest-indexed requester.
